// File: rtl/led_blink_arbiter_if.sv
// Request/rate inputs and LED/grant outputs of the LED arbiter.
// Requesters drive through master; the arbiter is the slave.
interface led_blink_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   iREQ;
    logic [2*N_REQ-1:0] iRATE;
    logic               oLED;
    logic [N_REQ-1:0]   oGNT;
    logic               oBUSY;

    modport master (
        output iREQ,
        output iRATE,
        input  oLED,
        input  oGNT,
        input  oBUSY
    );

    modport slave (
        input  iREQ,
        input  iRATE,
        output oLED,
        output oGNT,
        output oBUSY
    );
endinterface

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one LED between N_REQ requesters.
// Each grant blinks the LED at the winner's latched rate for a bounded window.
module led_blink_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned PRESC_W    = 20,
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic                iCLK,
    input  logic                iRSTn,
    led_blink_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int unsigned PH_W   = 3;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gnt_idx_q, gnt_idx_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          rate_q, rate_d;

    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic                tick;
    logic [PH_W-1:0]     phase_last;

    // First requesting index at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        logic [PTR_W-1:0] cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!pick_valid && bus.iREQ[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Blink period is 2^rate ticks; the LED toggles when phase reaches period-1.
    always_comb begin
        phase_last = '0;
        case (rate_q)
            2'd0:    phase_last = PH_W'(0);
            2'd1:    phase_last = PH_W'(1);
            2'd2:    phase_last = PH_W'(3);
            default: phase_last = PH_W'(7);
        endcase
    end

    assign tick = &presc_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_d     = gnt_q;
        led_d     = led_q;
        busy_d    = busy_q;
        presc_d   = presc_q + PRESC_W'(1);
        phase_d   = phase_q;
        hold_d    = hold_q;
        rate_d    = rate_q;

        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                led_d  = 1'b0;
                busy_d = 1'b0;
                if (pick_valid) begin
                    state_d   = SERVE;
                    gnt_idx_d = pick_idx;
                    gnt_d     = N_REQ'(1) << pick_idx;
                    led_d     = 1'b1;
                    busy_d    = 1'b1;
                    rate_d    = bus.iRATE[{pick_idx, 1'b0} +: 2];
                    presc_d   = '0;
                    phase_d   = '0;
                    hold_d    = '0;
                end
            end

            SERVE: begin
                // Early release wins over a tick landing on the same edge.
                if (!bus.iREQ[gnt_idx_q] || (tick && (hold_q == HOLD_LAST))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    led_d   = 1'b0;
                    busy_d  = 1'b0;
                    ptr_d   = (gnt_idx_q == PTR_LAST) ? '0 : gnt_idx_q + PTR_W'(1);
                end else if (tick) begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (phase_q == phase_last) begin
                        led_d   = ~led_q;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                led_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_q     <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            presc_q   <= '0;
            phase_q   <= '0;
            hold_q    <= '0;
            rate_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_q     <= gnt_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            rate_q    <= rate_d;
        end
    end

    assign bus.oLED  = led_q;
    assign bus.oGNT  = gnt_q;
    assign bus.oBUSY = busy_q;

endmodule
